// File: rtl/config_chain_pkg.sv
// Shared definitions for the configuration chain bank: controller state encoding
// and the bit-counter width helper.
package config_chain_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // The counter must reach CHLEN+1 so an over-long frame stays distinguishable.
    function automatic int cnt_width(input int chlen);
        return $clog2(chlen + 2);
    endfunction

endpackage

// File: rtl/config_chain_slice.sv
// One configuration chain: a serial shift register plus the shadow register that
// drives the live configuration.
module config_chain_slice #(
    parameter int               CHLEN  = 16,
    parameter logic [CHLEN-1:0] RSTVAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CHLEN-1:0] i_pin,
    input  logic             i_shift,
    input  logic             i_sdi,
    input  logic             i_commit,
    input  logic             i_restore,
    output logic             o_msb,
    output logic [CHLEN-1:0] o_sh
);

    logic [CHLEN-1:0] r_sr;
    logic [CHLEN-1:0] r_sh;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sr <= RSTVAL;
            r_sh <= RSTVAL;
        end else begin
            if (i_load)
                r_sr <= i_pin;
            else if (i_shift)
                r_sr <= {r_sr[CHLEN-2:0], i_sdi};
            else if (i_restore)
                r_sr <= r_sh;
            if (i_commit)
                r_sh <= r_sr;
        end
    end

    assign o_msb = r_sr[CHLEN-1];
    assign o_sh  = r_sh;

endmodule

// File: rtl/config_chain_bank.sv
// Bank of NCHAIN serially loaded configuration chains with checked, atomic commit
// of the selected chain into its shadow.
module config_chain_bank
    import config_chain_pkg::*;
#(
    parameter int                      NCHAIN = 2,
    parameter int                      CHLEN  = 16,
    parameter int                      SELW   = 1,
    parameter logic [NCHAIN*CHLEN-1:0] DEFVAL = '0
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [SELW-1:0]         SEL,
    input  logic                    SHIFT_EN,
    input  logic                    SDI,
    input  logic                    PLOAD,
    input  logic [NCHAIN*CHLEN-1:0] PIN,
    input  logic                    UPDATE,
    output logic                    SDO,
    output logic [NCHAIN*CHLEN-1:0] CFG_OUT,
    output logic                    UPD_OK,
    output logic                    UPD_ERR,
    output logic                    BUSY,
    output state_t                  DBG_STATE
);

    localparam int              CNTW    = cnt_width(CHLEN);
    localparam logic [CNTW-1:0] CNT_LEN = CNTW'(CHLEN);
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(CHLEN + 1);

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic            r_ferr;
    logic [SELW-1:0] r_addr;
    logic [SELW-1:0] r_csel;
    logic            r_cvalid;

    logic              w_sel_ok;
    logic              w_commit_go;
    logic [NCHAIN-1:0] w_msb;

    // Decode SEL against the implemented chains; SDO reads the selected MSB.
    always_comb begin
        w_sel_ok = 1'b0;
        SDO      = 1'b0;
        for (int c = 0; c < NCHAIN; c++) begin
            if (SEL == SELW'(c)) begin
                w_sel_ok = 1'b1;
                SDO      = w_msb[c];
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (PLOAD)
                    w_next = ST_IDLE;
                else if (UPDATE)
                    w_next = ST_COMMIT;
                else if (SHIFT_EN && w_sel_ok)
                    w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (PLOAD)
                    w_next = ST_IDLE;
                else if (UPDATE)
                    w_next = ST_COMMIT;
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // A PLOAD arriving during COMMIT cancels the commit, including its pulse.
    always_comb begin
        BUSY        = (r_state == ST_COMMIT);
        w_commit_go = BUSY && !PLOAD;
        UPD_OK      = w_commit_go && r_cvalid;
        UPD_ERR     = w_commit_go && !r_cvalid;
        DBG_STATE   = r_state;
    end

    // Frame bookkeeping: bit count, frame error, latched shift address, commit verdict.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt    <= '0;
            r_ferr   <= 1'b0;
            r_addr   <= '0;
            r_csel   <= '0;
            r_cvalid <= 1'b0;
        end else if (PLOAD || r_state == ST_COMMIT) begin
            r_cnt  <= '0;
            r_ferr <= 1'b0;
        end else if (UPDATE) begin
            r_csel   <= SEL;
            r_cvalid <= (r_state == ST_SHIFT) && (r_cnt == CNT_LEN) &&
                        !r_ferr && (SEL == r_addr);
        end else if (SHIFT_EN) begin
            if (!w_sel_ok) begin
                r_ferr <= 1'b1;
            end else begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + CNTW'(1);
                if (r_state == ST_IDLE)
                    r_addr <= SEL;
                else if (SEL != r_addr)
                    r_ferr <= 1'b1;
            end
        end
    end

    for (genvar c = 0; c < NCHAIN; c++) begin : g_chain
        logic w_shift;
        logic w_hit;

        assign w_hit   = (r_csel == SELW'(c));
        assign w_shift = SHIFT_EN && !PLOAD && !UPDATE && (r_state != ST_COMMIT) &&
                         (SEL == SELW'(c));

        config_chain_slice #(
            .CHLEN  (CHLEN),
            .RSTVAL (DEFVAL[c*CHLEN +: CHLEN])
        ) u_slice (
            .i_clk     (CLK),
            .i_rst_n   (RST_N),
            .i_load    (PLOAD),
            .i_pin     (PIN[c*CHLEN +: CHLEN]),
            .i_shift   (w_shift),
            .i_sdi     (SDI),
            .i_commit  (w_commit_go && r_cvalid && w_hit),
            .i_restore (w_commit_go && !r_cvalid && w_hit),
            .o_msb     (w_msb[c]),
            .o_sh      (CFG_OUT[c*CHLEN +: CHLEN])
        );
    end

endmodule

// File: tb/tb_config_chain_bank.sv
// Bench for config_chain_bank: directed frames plus randomised frame lengths, with
// commit outcomes checked through an expected-pulse scoreboard.
module tb_config_chain_bank;
  import config_chain_pkg::*;

  localparam int          W   = 2;
  localparam logic [31:0] DEF = {16'h9E37, 16'h4001};

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [0:0]  SEL;
  logic        SHIFT_EN;
  logic        SDI;
  logic        PLOAD;
  logic [31:0] PIN;
  logic        UPDATE;
  logic        SDO;
  logic [31:0] CFG_OUT;
  logic        UPD_OK;
  logic        UPD_ERR;
  logic        BUSY;
  state_t      DBG_STATE;

  int n_err = 0;
  int n_chk = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [15:0]  exp_sh[2];

  localparam logic [1:0] P_OK  = 2'b10;
  localparam logic [1:0] P_ERR = 2'b01;

  config_chain_bank #(
    .NCHAIN (2),
    .CHLEN  (16),
    .SELW   (1),
    .DEFVAL (DEF)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .SEL       (SEL),
    .SHIFT_EN  (SHIFT_EN),
    .SDI       (SDI),
    .PLOAD     (PLOAD),
    .PIN       (PIN),
    .UPDATE    (UPDATE),
    .SDO       (SDO),
    .CFG_OUT   (CFG_OUT),
    .UPD_OK    (UPD_OK),
    .UPD_ERR   (UPD_ERR),
    .BUSY      (BUSY),
    .DBG_STATE (DBG_STATE)
  );

  // clock / reset / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: act=%h req=%h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every COMMIT cycle consumes one expected pulse pair.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (BUSY) begin
        if (exp_q.size() == 0) begin
          check_eq("sb_unexpected_commit", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("upd_pulse", {30'd0, UPD_OK, UPD_ERR}, {30'd0, mon_e});
        end
      end else begin
        check_eq("pulse_idle", {30'd0, UPD_OK, UPD_ERR}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic shift_bits(input logic s, input logic [15:0] val, input int n);
    logic [15:0] t;
    t = val;
    SEL = s;
    SHIFT_EN = 1'b1;
    for (int i = 0; i < n; i++) begin
      SDI = t[15];
      t = {t[14:0], t[15]};
      cyc();
    end
    SHIFT_EN = 1'b0;
    SDI = 1'b0;
  endtask

  task automatic do_update(input logic s, input logic [1:0] exp_pulse);
    SEL = s;
    UPDATE = 1'b1;
    exp_q.push_back(exp_pulse);
    cyc();
    UPDATE = 1'b0;
    check_eq("busy_commit", {31'd0, BUSY}, 32'd1);
    check_eq("dbg_state_commit", {30'd0, DBG_STATE}, {30'd0, ST_COMMIT});
    cyc();
    check_eq("busy_one_cycle", {31'd0, BUSY}, 32'd0);
    check_eq("sb_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Serial readout that rotates the chain so its contents survive the read.
  task automatic read_chain(input logic s, output logic [15:0] v);
    SEL = s;
    #1;
    SHIFT_EN = 1'b1;
    for (int i = 0; i < 16; i++) begin
      v[15-i] = SDO;
      SDI = SDO;
      cyc();
    end
    SHIFT_EN = 1'b0;
    SDI = 1'b0;
  endtask

  task automatic check_cfg(input string tag);
    check_eq({tag, "_cfg0"}, {16'd0, CFG_OUT[15:0]}, {16'd0, exp_sh[0]});
    check_eq({tag, "_cfg1"}, {16'd0, CFG_OUT[31:16]}, {16'd0, exp_sh[1]});
  endtask

  initial begin
    logic [15:0] rd;
    logic        rs;
    logic [15:0] rv;
    int          rl;

    RST_N = 1'b0;
    SEL = 1'b0;
    SHIFT_EN = 1'b0;
    SDI = 1'b0;
    PLOAD = 1'b0;
    PIN = '0;
    UPDATE = 1'b0;
    exp_sh[0] = 16'h4001;
    exp_sh[1] = 16'h9E37;

    // reset state
    #12;
    check_eq("rst_cfg", CFG_OUT, DEF);
    check_eq("rst_sdo_sel0", {31'd0, SDO}, 32'd0);
    check_eq("rst_flags", {29'd0, BUSY, UPD_OK, UPD_ERR}, 32'd0);
    SEL = 1'b1;
    #1;
    check_eq("rst_sdo_sel1", {31'd0, SDO}, 32'd1);
    SEL = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();

    // full-length frame into chain 1 commits
    shift_bits(1'b1, 16'hA5C3, 16);
    check_cfg("pre_commit");
    do_update(1'b1, P_OK);
    exp_sh[1] = 16'hA5C3;
    check_cfg("commit_a5c3");

    // short frame is rejected and the shift register restored from the shadow
    shift_bits(1'b0, 16'hFFFF, 15);
    do_update(1'b0, P_ERR);
    check_cfg("short_frame");
    read_chain(1'b0, rd);
    check_eq("short_restore_sr0", {16'd0, rd}, 32'h4001);
    do_update(1'b0, P_OK);
    check_cfg("short_recommit");

    // chain switch mid-frame flags a frame error
    shift_bits(1'b0, 16'h00FF, 8);
    shift_bits(1'b1, 16'h3C3C, 8);
    do_update(1'b1, P_ERR);
    check_cfg("frame_err");
    read_chain(1'b1, rd);
    check_eq("frame_err_restore_sr1", {16'd0, rd}, 32'hA5C3);
    do_update(1'b1, P_OK);

    // PLOAD wins over UPDATE in the same cycle
    PIN = 32'h1234_5678;
    PLOAD = 1'b1;
    UPDATE = 1'b1;
    SEL = 1'b1;
    cyc();
    PLOAD = 1'b0;
    UPDATE = 1'b0;
    check_eq("pload_no_commit", {31'd0, BUSY}, 32'd0);
    check_eq("pload_sdo_sel1", {31'd0, SDO}, 32'd0);
    check_cfg("pload_sh_hold");
    read_chain(1'b1, rd);
    check_eq("pload_sr1", {16'd0, rd}, 32'h1234);
    do_update(1'b1, P_OK);
    exp_sh[1] = 16'h1234;
    read_chain(1'b0, rd);
    check_eq("pload_sr0", {16'd0, rd}, 32'h5678);
    do_update(1'b0, P_OK);
    exp_sh[0] = 16'h5678;
    check_cfg("pload_commit");

    // random frames around the length boundary (15, 16, 17 bits)
    for (int k = 0; k < 8; k++) begin
      rs = 1'($urandom_range(0, 1));
      rv = 16'($urandom_range(0, 65535));
      rl = $urandom_range(15, 17);
      shift_bits(rs, rv, rl);
      do_update(rs, (rl == 16) ? P_OK : P_ERR);
      if (rl == 16) exp_sh[rs] = rv;
      check_cfg("rand_frame");
    end

    // reset asserted during COMMIT discards the commit
    shift_bits(1'b0, 16'h0F0F, 16);
    SEL = 1'b0;
    UPDATE = 1'b1;
    cyc();
    UPDATE = 1'b0;
    check_eq("rstc_busy", {31'd0, BUSY}, 32'd1);
    #2;
    RST_N = 1'b0;
    #1;
    exp_sh[0] = 16'h4001;
    exp_sh[1] = 16'h9E37;
    check_eq("rstc_flags", {29'd0, BUSY, UPD_OK, UPD_ERR}, 32'd0);
    check_cfg("rstc_during");
    @(negedge CLK);
    RST_N = 1'b1;
    cyc();
    check_cfg("rstc_after");
    check_eq("rstc_sdo_sel0", {31'd0, SDO}, 32'd0);
    check_eq("rstc_state", {30'd0, DBG_STATE}, {30'd0, ST_IDLE});
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
